// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundles the trap sequencer's CSR-file, core-status and fetch-redirect signals.
//   master : trap_ctrl side (drives CSR read/write port 2, trap strobe, busy, redirect).
//   slave  : core / CSR file / fetch side (drives status bits, boundary, pc, mret, read data, ready).
interface trap_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3
);
    logic                  i_mie_mstatus;
    logic                  i_mtie_mie;
    logic                  i_mtip_mip;
    logic                  i_instr_boundary;
    logic [DATA_WIDTH-1:0] i_pc;
    logic                  i_mret;
    logic [DATA_WIDTH-1:0] i_csr_read_data;
    logic [ADDR_WIDTH-1:0] o_csr_read_addr;
    logic                  o_csr_write_en;
    logic [ADDR_WIDTH-1:0] o_csr_write_addr;
    logic [DATA_WIDTH-1:0] o_csr_write_data;
    logic                  o_timer_int_jump;
    logic                  o_trap_busy;
    logic                  o_redirect_valid;
    logic [DATA_WIDTH-1:0] o_redirect_pc;
    logic                  i_redirect_ready;

    modport master (
        input  i_mie_mstatus, i_mtie_mie, i_mtip_mip, i_instr_boundary, i_pc, i_mret,
               i_csr_read_data, i_redirect_ready,
        output o_csr_read_addr, o_csr_write_en, o_csr_write_addr, o_csr_write_data,
               o_timer_int_jump, o_trap_busy, o_redirect_valid, o_redirect_pc
    );

    modport slave (
        output i_mie_mstatus, i_mtie_mie, i_mtip_mip, i_instr_boundary, i_pc, i_mret,
               i_csr_read_data, i_redirect_ready,
        input  o_csr_read_addr, o_csr_write_en, o_csr_write_addr, o_csr_write_data,
               o_timer_int_jump, o_trap_busy, o_redirect_valid, o_redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode timer-interrupt and mret sequencer downstream of the CSR file.
//   clk   : rising-edge clock
//   arstn : asynchronous active-low reset
//   bus   : trap_ctrl_if.master -- CSR status inputs, CSR read/write port 2,
//           MIE-clear strobe, core stall, fetch redirect handshake
module trap_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 3,
    parameter logic [DATA_WIDTH-1:0] MCAUSE_TIMER = {1'b1, {(DATA_WIDTH-5){1'b0}}, 4'd7}
) (
    input logic         clk,
    input logic         arstn,
    trap_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] A_MSTATUS = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_MTVEC   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_MCAUSE  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_MEPC    = ADDR_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] ALIGN     = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] VEC_OFF   = DATA_WIDTH'(28);
    localparam logic [DATA_WIDTH-1:0] MIE_BIT   = DATA_WIDTH'(8);

    typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_VEC, M_STATUS, M_EPC, REDIRECT} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, rpc_q, rpc_d;
    logic                  pending;

    assign pending = bus.i_mie_mstatus & bus.i_mtie_mie & bus.i_mtip_mip;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
            pc_q  <= '0;
            rpc_q <= '0;
        end else begin
            state <= state_d;
            pc_q  <= pc_d;
            rpc_q <= rpc_d;
        end
    end

    always_comb begin
        state_d                = state;
        pc_d                   = pc_q;
        rpc_d                  = rpc_q;
        bus.o_csr_read_addr    = '0;
        bus.o_csr_write_en     = 1'b0;
        bus.o_csr_write_addr   = '0;
        bus.o_csr_write_data   = '0;
        bus.o_timer_int_jump   = 1'b0;
        bus.o_redirect_valid   = 1'b0;
        case (state)
            IDLE: begin
                // interrupt wins over a simultaneous mret; the mret re-executes after the handler
                if (bus.i_instr_boundary && pending) begin
                    pc_d    = bus.i_pc & ALIGN;
                    state_d = T_EPC;
                end else if (bus.i_mret) begin
                    state_d = M_STATUS;
                end
            end
            T_EPC: begin
                bus.o_csr_write_en   = 1'b1;
                bus.o_csr_write_addr = A_MEPC;
                bus.o_csr_write_data = pc_q;
                state_d              = T_CAUSE;
            end
            T_CAUSE: begin
                bus.o_csr_write_en   = 1'b1;
                bus.o_csr_write_addr = A_MCAUSE;
                bus.o_csr_write_data = MCAUSE_TIMER;
                bus.o_timer_int_jump = 1'b1;
                bus.o_csr_read_addr  = A_MTVEC;
                state_d              = T_VEC;
            end
            T_VEC: begin
                // only mode 01 is vectored; modes 10/11 fall back to direct
                bus.o_csr_read_addr = A_MTVEC;
                rpc_d   = (bus.i_csr_read_data & ALIGN)
                        + ((bus.i_csr_read_data[1:0] == 2'b01) ? VEC_OFF : '0);
                state_d = REDIRECT;
            end
            M_STATUS: begin
                // single-cycle read-modify-write of mstatus via the combinational read port
                bus.o_csr_read_addr  = A_MSTATUS;
                bus.o_csr_write_en   = 1'b1;
                bus.o_csr_write_addr = A_MSTATUS;
                bus.o_csr_write_data = bus.i_csr_read_data | MIE_BIT;
                state_d              = M_EPC;
            end
            M_EPC: begin
                bus.o_csr_read_addr = A_MEPC;
                rpc_d               = bus.i_csr_read_data & ALIGN;
                state_d             = REDIRECT;
            end
            REDIRECT: begin
                bus.o_redirect_valid = 1'b1;
                state_d              = bus.i_redirect_ready ? IDLE : REDIRECT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_trap_busy   = (state != IDLE);
    assign bus.o_redirect_pc = rpc_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: table-driven and directed self-checking bench for trap_ctrl with a small CSR-file model.
module tb_trap_ctrl;
    localparam logic [63:0] MC = 64'h8000_0000_0000_0007;

    typedef struct {
        logic        bnd, mret, mie, mtie, mtip, rdy;
        logic [63:0] pc, mtvec;
        logic        busy, we;
        logic [2:0]  wa;
        logic [63:0] wd;
        logic        jump, rv;
        logic [63:0] rpc;
        logic        rachk;
        logic [2:0]  ra;
    } vec_t;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [63:0] mtvec = '0;
    logic [63:0] csr [8];
    logic        set_en = 1'b0;
    logic [2:0]  set_a = '0;
    logic [63:0] set_d = '0;
    int          n_wr = 0, n_wr0 = 0;
    int          checks = 0, failures = 0;
    vec_t        tbl[$];

    trap_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) bus ();

    trap_ctrl dut (.clk(clk), .arstn(arstn), .bus(bus.master));

    always #5 clk = ~clk;

    assign bus.i_csr_read_data = (bus.o_csr_read_addr == 3'd3) ? mtvec : csr[bus.o_csr_read_addr];

    always @(posedge clk) begin
        if (bus.o_csr_write_en) begin
            csr[bus.o_csr_write_addr] <= bus.o_csr_write_data;
            n_wr <= n_wr + 1;
            if (bus.o_csr_write_addr == 3'd0) n_wr0 <= n_wr0 + 1;
        end else if (set_en) begin
            csr[set_a] <= set_d;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic bnd, mret, mie, mtie, mtip, rdy, input logic [63:0] pc);
        bus.i_instr_boundary = bnd;
        bus.i_mret           = mret;
        bus.i_mie_mstatus    = mie;
        bus.i_mtie_mie       = mtie;
        bus.i_mtip_mip       = mtip;
        bus.i_redirect_ready = rdy;
        bus.i_pc             = pc;
    endtask

    task automatic preload(input logic [2:0] a, input logic [63:0] d);
        set_a = a; set_d = d; set_en = 1'b1;
        step();
        set_en = 1'b0;
    endtask

    task automatic add(input logic bnd, mret, mie, mtie, mtip, rdy, input logic [63:0] pc, mt,
                       input logic busy, we, input logic [2:0] wa, input logic [63:0] wd,
                       input logic jump, rv, input logic [63:0] rpc, input logic rachk,
                       input logic [2:0] ra);
        vec_t v;
        v.bnd = bnd; v.mret = mret; v.mie = mie; v.mtie = mtie; v.mtip = mtip; v.rdy = rdy;
        v.pc = pc; v.mtvec = mt; v.busy = busy; v.we = we; v.wa = wa; v.wd = wd;
        v.jump = jump; v.rv = rv; v.rpc = rpc; v.rachk = rachk; v.ra = ra;
        tbl.push_back(v);
    endtask

    // one complete trap: boundary row, four sequencer rows, one trailing idle row
    task automatic add_trap(input logic [63:0] pc, mt, mepc, tgt, input logic mtip1, exit_pend);
        add(1, 0, 1, 1, 1,     0, pc, mt, 0, 0, 0, 0,    0, 0, 0,   0, 0);
        add(0, 0, 1, 1, mtip1, 0, 0,  mt, 1, 1, 5, mepc, 0, 0, 0,   0, 0);
        add(0, 0, 1, 1, mtip1, 0, 0,  mt, 1, 1, 4, MC,   1, 0, 0,   1, 3);
        add(0, 0, 1, 1, mtip1, 0, 0,  mt, 1, 0, 0, 0,    0, 0, 0,   1, 3);
        add(exit_pend, 0, 1, 1, 1, 1, pc, mt, 1, 0, 0, 0, 0, 1, tgt, 0, 0);
        add(0, 0, 0, 0, 0,     0, 0,  mt, 0, 0, 0, 0,    0, 0, 0,   0, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_busy", bus.o_trap_busy, 0);
        chk("rst_we", bus.o_csr_write_en, 0);
        chk("rst_rv", bus.o_redirect_valid, 0);
        chk("rst_rpc", bus.o_redirect_pc, 0);
        chk("rst_ra", bus.o_csr_read_addr, 0);
        step();
        arstn = 1'b1;
        preload(0, 64'h1800);

        add_trap(64'h2006, 64'h8000_0100, 64'h2004, 64'h8000_0100, 1, 0);
        add_trap(64'h1000, 64'h8000_0101, 64'h1000, 64'h8000_011C, 0, 0);
        add_trap(64'h2A0B, 64'hFFFF_FFFF_FFFF_FFF1, 64'h2A08, 64'h0000_0000_0000_000C, 1, 1);
        add_trap(64'h0050, 64'h8000_0202, 64'h0050, 64'h8000_0200, 1, 0);
        add(0, 0, 1, 1, 1, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 1, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 64'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].bnd, tbl[i].mret, tbl[i].mie, tbl[i].mtie, tbl[i].mtip, tbl[i].rdy, tbl[i].pc);
            mtvec = tbl[i].mtvec;
            #3;
            chk($sformatf("r%0d_busy", i), bus.o_trap_busy, tbl[i].busy);
            chk($sformatf("r%0d_we", i), bus.o_csr_write_en, tbl[i].we);
            chk($sformatf("r%0d_jump", i), bus.o_timer_int_jump, tbl[i].jump);
            chk($sformatf("r%0d_rv", i), bus.o_redirect_valid, tbl[i].rv);
            if (tbl[i].we) begin
                chk($sformatf("r%0d_waddr", i), bus.o_csr_write_addr, tbl[i].wa);
                chk($sformatf("r%0d_wdata", i), bus.o_csr_write_data, tbl[i].wd);
            end
            if (tbl[i].rachk) chk($sformatf("r%0d_raddr", i), bus.o_csr_read_addr, tbl[i].ra);
            if (tbl[i].rv) chk($sformatf("r%0d_rpc", i), bus.o_redirect_pc, tbl[i].rpc);
            step();
        end
        chk("trap_mcause", csr[4], MC);

        // mret with the fetch stage stalling the redirect for three cycles
        drive(0, 0, 0, 0, 0, 0, 0);
        preload(0, 64'h1800);
        preload(5, 64'h4000);
        drive(0, 1, 0, 0, 0, 0, 0);
        #3 chk("mret_n_busy", bus.o_trap_busy, 0);
        step();
        bus.i_mret = 1'b0;
        #3;
        chk("mret_st_we", bus.o_csr_write_en, 1);
        chk("mret_st_waddr", bus.o_csr_write_addr, 0);
        chk("mret_st_wdata", bus.o_csr_write_data, 64'h1808);
        chk("mret_st_raddr", bus.o_csr_read_addr, 0);
        step();
        #3;
        chk("mret_epc_we", bus.o_csr_write_en, 0);
        chk("mret_epc_raddr", bus.o_csr_read_addr, 5);
        chk("mret_epc_rv", bus.o_redirect_valid, 0);
        chk("mret_mstatus", csr[0], 64'h1808);
        for (int k = 0; k < 3; k++) begin
            step();
            #3;
            chk($sformatf("mret_hold%0d_rv", k), bus.o_redirect_valid, 1);
            chk($sformatf("mret_hold%0d_rpc", k), bus.o_redirect_pc, 64'h4000);
            chk($sformatf("mret_hold%0d_busy", k), bus.o_trap_busy, 1);
        end
        step();
        bus.i_redirect_ready = 1'b1;
        #3 chk("mret_acc_rv", bus.o_redirect_valid, 1);
        step();
        bus.i_redirect_ready = 1'b0;
        #3;
        chk("mret_done_rv", bus.o_redirect_valid, 0);
        chk("mret_done_busy", bus.o_trap_busy, 0);

        // interrupt and mret in the same cycle: trap wins, mstatus untouched
        preload(0, 64'h1800);
        mtvec = 64'h8000_0100;
        begin
            int n0;
            n0 = n_wr0;
            drive(1, 1, 1, 1, 1, 0, 64'h3000);
            step();
            drive(0, 0, 1, 1, 1, 1, 0);
            #3;
            chk("sim_we", bus.o_csr_write_en, 1);
            chk("sim_waddr", bus.o_csr_write_addr, 5);
            chk("sim_wdata", bus.o_csr_write_data, 64'h3000);
            step(); step(); step();
            #3;
            chk("sim_rv", bus.o_redirect_valid, 1);
            chk("sim_rpc", bus.o_redirect_pc, 64'h8000_0100);
            step();
            bus.i_redirect_ready = 1'b0;
            #3;
            chk("sim_busy", bus.o_trap_busy, 0);
            chk("sim_mepc", csr[5], 64'h3000);
            chk("sim_mstatus_wr", n_wr0, n0);
            chk("sim_mstatus", csr[0], 64'h1800);
        end

        // asynchronous reset in the middle of T_CAUSE
        drive(1, 0, 1, 1, 1, 0, 64'h2006);
        step();
        drive(0, 0, 1, 1, 1, 0, 0);
        step();
        #3 chk("ar_jump_pre", bus.o_timer_int_jump, 1);
        arstn = 1'b0;
        #1;
        chk("ar_busy", bus.o_trap_busy, 0);
        chk("ar_we", bus.o_csr_write_en, 0);
        chk("ar_jump", bus.o_timer_int_jump, 0);
        chk("ar_rv", bus.o_redirect_valid, 0);
        chk("ar_rpc", bus.o_redirect_pc, 0);
        chk("ar_raddr", bus.o_csr_read_addr, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step(); step();
        arstn = 1'b1;
        begin
            int nw;
            nw = n_wr;
            repeat (5) step();
            #3;
            chk("ar_no_writes", n_wr, nw);
            chk("ar_idle_busy", bus.o_trap_busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
